// File: rtl/mdu_multicycle_pkg.sv
// Shared opcode encoding, FSM states, default latencies and opcode class helpers
// for the multi-cycle multiply/divide unit.
`default_nettype none

package mdu_multicycle_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MFHI  = 4'd9,
        OP_MFLO  = 4'd10,
        OP_MTHI  = 4'd11,
        OP_MTLO  = 4'd12
    } mdu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'(OP_MULT)) && (op <= 4'(OP_MSUBU));
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == 4'(OP_DIV)) || (op == 4'(OP_DIVU));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_multicycle_if.sv
// E-stage <-> MDU bundle: opcode, forwarded operands, flush, handshake and HI/LO read-out.
`default_nettype none

interface mdu_multicycle_if #(
    parameter int WIDTH = 32
) ();
    logic [3:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             start_o;
    logic             busy_o;
    logic [WIDTH-1:0] rdata_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output op_i, a_i, b_i, flush_i,
        input  start_o, busy_o, rdata_o, hi_o, lo_o
    );

    modport slave (
        input  op_i, a_i, b_i, flush_i,
        output start_o, busy_o, rdata_o, hi_o, lo_o
    );
endinterface

`default_nettype wire

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit: result computed at start, held in a pending
// register and committed to HI/LO after a programmable down-counted latency.
`default_nettype none

module mdu_multicycle
    import mdu_multicycle_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mdu_multicycle_if.slave  bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e         state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, pend_hi_q, pend_lo_q;

    logic [2*WIDTH-1:0] acc, prod_s, prod_u, res_d;
    logic [WIDTH-1:0]   a, b, div_b, abs_a, abs_b, qmag, rmag, quot_s, rem_s;
    logic               b_zero, start;
    logic [CNT_W-1:0]   lat_d;

    assign a      = bus.a_i;
    assign b      = bus.b_i;
    assign b_zero = (b == '0);
    assign acc    = {hi_q, lo_q};
    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide via magnitudes: avoids the min/-1 overflow trap and naturally
    // yields quotient=min, remainder=0 for that case.
    assign div_b  = b_zero ? CNT_W'(0) + WIDTH'(1) : b;
    assign abs_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign abs_b  = div_b[WIDTH-1] ? (~div_b + 1'b1) : div_b;
    assign qmag   = abs_a / abs_b;
    assign rmag   = abs_a % abs_b;
    assign quot_s = (a[WIDTH-1] ^ div_b[WIDTH-1]) ? (~qmag + 1'b1) : qmag;
    assign rem_s  = a[WIDTH-1] ? (~rmag + 1'b1) : rmag;

    assign start  = is_muldiv(bus.op_i) && (state_q == ST_IDLE) && !bus.flush_i;
    assign lat_d  = is_div(bus.op_i) ? DIV_CNT : MULT_CNT;

    always_comb begin
        res_d = acc;
        case (bus.op_i)
            OP_MULT:  res_d = prod_s;
            OP_MULTU: res_d = prod_u;
            OP_MADD:  res_d = acc + prod_s;
            OP_MADDU: res_d = acc + prod_u;
            OP_MSUB:  res_d = acc - prod_s;
            OP_MSUBU: res_d = acc - prod_u;
            OP_DIV:   if (!b_zero) res_d = {rem_s, quot_s};
            OP_DIVU:  if (!b_zero) res_d = {a % div_b, a / div_b};
            default:  res_d = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pend_hi_q <= res_d[2*WIDTH-1:WIDTH];
                        pend_lo_q <= res_d[WIDTH-1:0];
                        cnt_q     <= lat_d;
                        state_q   <= ST_BUSY;
                        busy_q    <= 1'b1;
                    end else if (!bus.flush_i) begin
                        if (bus.op_i == OP_MTHI) hi_q <= a;
                        if (bus.op_i == OP_MTLO) lo_q <= a;
                    end
                end
                ST_BUSY: begin
                    // Abort takes priority even on the final cycle: nothing commits.
                    if (bus.flush_i) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        cnt_q     <= '0;
                        pend_hi_q <= '0;
                        pend_lo_q <= '0;
                    end else if (cnt_q == '0) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.rdata_o = '0;
        if (bus.op_i == OP_MFHI) bus.rdata_o = hi_q;
        if (bus.op_i == OP_MFLO) bus.rdata_o = lo_q;
    end

    assign bus.start_o = start;
    assign bus.busy_o  = busy_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_multicycle.sv
// Directed and randomized checks of mdu_multicycle against a plain-arithmetic HI/LO model.
`default_nettype none

module tb_mdu_multicycle;
    import mdu_multicycle_pkg::*;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_multicycle_if #(.WIDTH(W)) bus ();

    mdu_multicycle #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one completed op, from the instruction definitions.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] acc, ps, pu;
        sa  = $signed(a);
        sb  = $signed(b);
        acc = {m_hi, m_lo};
        ps  = sa * sb;
        pu  = {32'h0, a} * {32'h0, b};
        case (op)
            4'd1: acc = ps;
            4'd2: acc = pu;
            4'd5: acc = acc + ps;
            4'd6: acc = acc + pu;
            4'd7: acc = acc - ps;
            4'd8: acc = acc - pu;
            4'd3: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                acc = {32'(r), 32'(q)};
            end
            4'd4: if (b != 0) acc = {a % b, a / b};
            4'd11: acc[63:32] = a;
            4'd12: acc[31:0]  = a;
            default: ;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
    endtask

    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int n;
        int lat;
        lat = (op == 4'd3 || op == 4'd4) ? DL : ML;
        @(negedge clk);
        bus.op_i = op; bus.a_i = a; bus.b_i = b;
        #1 check({tag, "_start"}, 64'(bus.start_o), 64'd1);
        model(op, a, b);
        @(negedge clk);
        bus.op_i = 4'd0;
        n = 0;
        while (bus.busy_o === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
    endtask

    task automatic run_simple(input logic [3:0] op, input logic [31:0] a, input string tag);
        logic [31:0] exp_rd;
        exp_rd = (op == 4'd9) ? m_hi : (op == 4'd10) ? m_lo : 32'h0;
        @(negedge clk);
        bus.op_i = op; bus.a_i = a;
        #1 check({tag, "_start"}, 64'(bus.start_o), 64'd0);
        check({tag, "_rdata"}, 64'(bus.rdata_o), 64'(exp_rd));
        model(op, a, 32'h0);
        @(negedge clk);
        bus.op_i = 4'd0;
        check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
    endtask

    initial begin
        logic [31:0] ra, rb, old_hi, old_lo;
        logic [3:0]  rop;
        int sel;

        bus.op_i = 4'd0; bus.a_i = '0; bus.b_i = '0; bus.flush_i = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        check("reset_start", 64'(bus.start_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_md(4'd1, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
        check("mult_m3x7_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_md(4'd4, 32'd100, 32'd7, "divu_100_7");
        check("divu_100_7_const", {bus.hi_o, bus.lo_o}, {32'd2, 32'd14});
        run_md(4'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        check("div_m7_2_const", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_simple(4'd11, 32'd5, "mthi5");
        run_simple(4'd12, 32'd9, "mtlo9");
        run_md(4'd3, 32'd1234, 32'd0, "div_by0");
        check("div_by0_const", {bus.hi_o, bus.lo_o}, {32'd5, 32'd9});
        run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        check("div_min_m1_const", {bus.hi_o, bus.lo_o}, {32'h0, 32'h8000_0000});
        run_simple(4'd11, 32'd1, "mthi1");
        run_simple(4'd12, 32'hFFFF_FFFF, "mtloF");
        run_md(4'd6, 32'd1, 32'd1, "maddu");
        check("maddu_const", {bus.hi_o, bus.lo_o}, {32'd2, 32'd0});
        run_md(4'd7, 32'd1, 32'd1, "msub");
        check("msub_const", {bus.hi_o, bus.lo_o}, {32'd1, 32'hFFFF_FFFF});

        // Flush on busy cycle 3, with a stray mthi on cycle 2 that must be ignored.
        old_hi = m_hi; old_lo = m_lo;
        @(negedge clk);
        bus.op_i = 4'd1; bus.a_i = 32'd11; bus.b_i = 32'd13;
        @(negedge clk);
        bus.op_i = 4'd0;
        @(negedge clk);
        bus.op_i = 4'd11; bus.a_i = 32'hDEAD_BEEF;
        #1 check("busy_mthi_start", 64'(bus.start_o), 64'd0);
        @(negedge clk);
        bus.op_i = 4'd0; bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_busy", 64'(bus.busy_o), 64'd0);
        check("flush_hilo", {bus.hi_o, bus.lo_o}, {old_hi, old_lo});
        bus.op_i = 4'd10;
        #1 check("flush_mflo", 64'(bus.rdata_o), 64'(old_lo));

        // Flush on the final busy cycle: abort beats commit.
        @(negedge clk);
        bus.op_i = 4'd2; bus.a_i = 32'd3; bus.b_i = 32'd4;
        @(negedge clk);
        bus.op_i = 4'd0;
        repeat (ML - 1) @(negedge clk);
        check("last_cycle_busy", 64'(bus.busy_o), 64'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        check("last_flush_busy", 64'(bus.busy_o), 64'd0);
        check("last_flush_hilo", {bus.hi_o, bus.lo_o}, {old_hi, old_lo});

        // Flush while idle suppresses both start and mt*.
        bus.op_i = 4'd1; bus.a_i = 32'd5; bus.b_i = 32'd5;
        #1 check("idle_flush_start", 64'(bus.start_o), 64'd0);
        @(negedge clk);
        check("idle_flush_busy", 64'(bus.busy_o), 64'd0);
        bus.op_i = 4'd11; bus.a_i = 32'h1234_5678;
        @(negedge clk);
        check("idle_flush_mthi", {bus.hi_o, bus.lo_o}, {old_hi, old_lo});
        bus.flush_i = 1'b0; bus.op_i = 4'd0;

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 15);
            rop = sel[3:0];
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = $urandom_range(1, 15);
                default: ;
            endcase
            if (rop >= 4'd1 && rop <= 4'd8) run_md(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop));
            else run_simple(rop, ra, $sformatf("rnd%0d_op%0d", i, rop));
        end

        // Asynchronous reset mid-divide.
        @(negedge clk);
        bus.op_i = 4'd3; bus.a_i = 32'd99; bus.b_i = 32'd4;
        @(negedge clk);
        bus.op_i = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run_md(4'd1, 32'd2, 32'd3, "post_rst_mult");
        check("post_rst_lo6", 64'(bus.lo_o), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
